// File: rtl/kitt_mode_sequencer.sv
// KITT mode sequencer: drives the scan core's ENA/MODE/SPEED/OINV inputs,
// with manual pass-through or an auto-demo, and ENA-low blanking on every change.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   en_in, auto_in      : master enable, auto-demo select (levels)
//   btn_next            : step button level (rising edge detected here)
//   man_mode/man_speed  : manual pattern request
//   man_oinv            : output-invert request (all modes)
//   core_ena/core_mode/core_speed/core_oinv : registered core controls
//   step_idx            : current auto step
//   busy                : high while blanking
module kitt_mode_sequencer #(
  parameter int unsigned PRESCALE    = 10000,
  parameter int unsigned DWELL_TICKS = 2000,
  parameter int unsigned BLANK_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_in,
  input  logic       auto_in,
  input  logic       btn_next,
  input  logic [1:0] man_mode,
  input  logic       man_speed,
  input  logic       man_oinv,
  output logic       core_ena,
  output logic [1:0] core_mode,
  output logic       core_speed,
  output logic       core_oinv,
  output logic [2:0] step_idx,
  output logic       busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          btn_q, btn_d;
  logic          auto_q, auto_d;
  logic          ena_q, ena_d;
  logic          busy_q, busy_d;
  logic [1:0]    mode_q, mode_d;
  logic          speed_q, speed_d;
  logic          oinv_q, oinv_d;
  logic [2:0]    step_q, step_d;

  logic          tick;
  logic          rise;
  logic          dwell_exp;
  logic          load;
  logic          adv;
  logic [2:0]    step_nx;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    auto_d  = auto_q;
    ena_d   = ena_q;
    busy_d  = busy_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    step_d  = step_q;
    btn_d   = btn_next;
    oinv_d  = man_oinv;
    load    = 1'b0;
    adv     = 1'b0;
    step_nx = step_q;

    tick      = (pre_q == PW'(PRESCALE - 1));
    pre_d     = tick ? '0 : pre_q + PW'(1);
    rise      = btn_next & ~btn_q;
    dwell_exp = tick && (dwell_q == DW'(DWELL_TICKS - 1));

    if (!en_in) begin
      state_d = S_OFF;
      ena_d   = 1'b0;
      busy_d  = 1'b0;
      pre_d   = '0;
      dwell_d = '0;
      blank_d = '0;
    end else begin
      unique case (state_q)
        S_OFF: load = 1'b1;
        S_BLANK: begin
          if (tick) begin
            if (blank_q == BW'(BLANK_TICKS - 1)) begin
              state_d = S_RUN;
              ena_d   = 1'b1;
              busy_d  = 1'b0;
              pre_d   = '0;
              dwell_d = '0;
              blank_d = '0;
            end else begin
              blank_d = blank_q + BW'(1);
            end
          end
        end
        S_RUN: begin
          // Switching into auto applies the held step without advancing.
          if (auto_in != auto_q) begin
            load = 1'b1;
          end else if (!auto_in) begin
            if ({man_mode, man_speed} != {mode_q, speed_q}) load = 1'b1;
          end else if (dwell_exp || rise) begin
            load = 1'b1;
            adv  = 1'b1;
          end else if (tick) begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (load) begin
      state_d = S_BLANK;
      ena_d   = 1'b0;
      busy_d  = 1'b1;
      pre_d   = '0;
      dwell_d = '0;
      blank_d = '0;
      auto_d  = auto_in;
      if (auto_in) begin
        step_nx = adv ? step_q + 3'd1 : step_q;
        step_d  = step_nx;
        mode_d  = step_nx[1:0];
        speed_d = step_nx[2];
      end else begin
        mode_d  = man_mode;
        speed_d = man_speed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      pre_q   <= '0;
      dwell_q <= '0;
      blank_q <= '0;
      btn_q   <= 1'b0;
      auto_q  <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 2'd0;
      speed_q <= 1'b0;
      oinv_q  <= 1'b0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      btn_q   <= btn_d;
      auto_q  <= auto_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      oinv_q  <= oinv_d;
      step_q  <= step_d;
    end
  end

  assign core_ena   = ena_q;
  assign core_mode  = mode_q;
  assign core_speed = speed_q;
  assign core_oinv  = oinv_q;
  assign step_idx   = step_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_kitt_mode_sequencer.sv
// Testbench for kitt_mode_sequencer: vector table plus scoreboard queue,
// with PRESCALE=4, DWELL_TICKS=3, BLANK_TICKS=2.
module tb_kitt_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_in = 1'b0;
  logic       auto_in = 1'b0;
  logic       btn_next = 1'b0;
  logic [1:0] man_mode = 2'd0;
  logic       man_speed = 1'b0;
  logic       man_oinv = 1'b0;
  logic       core_ena;
  logic [1:0] core_mode;
  logic       core_speed;
  logic       core_oinv;
  logic [2:0] step_idx;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kitt_mode_sequencer #(
    .PRESCALE(4),
    .DWELL_TICKS(3),
    .BLANK_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_in(en_in),
    .auto_in(auto_in),
    .btn_next(btn_next),
    .man_mode(man_mode),
    .man_speed(man_speed),
    .man_oinv(man_oinv),
    .core_ena(core_ena),
    .core_mode(core_mode),
    .core_speed(core_speed),
    .core_oinv(core_oinv),
    .step_idx(step_idx),
    .busy(busy)
  );

  // expected bundle: {ena, mode[1:0], speed, oinv, step[2:0], busy}
  typedef struct {
    logic       en;
    logic       au;
    logic       btn;
    logic [1:0] mm;
    logic       ms;
    logic       oi;
    int         n;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [8:0] sb[$];

  function automatic void add(
    input logic en, input logic au, input logic btn,
    input logic [1:0] mm, input logic ms, input logic oi, input int n,
    input logic ena, input logic [1:0] mo, input logic sp,
    input logic ov, input logic [2:0] st, input logic bz);
    vec_t v;
    v.en = en; v.au = au; v.btn = btn;
    v.mm = mm; v.ms = ms; v.oi = oi; v.n = n;
    v.exp = {ena, mo, sp, ov, st, bz};
    vecs.push_back(v);
  endfunction

  function automatic logic [8:0] outs();
    return {core_ena, core_mode, core_speed, core_oinv, step_idx, busy};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got={ena,mode,spd,oinv,step,busy}=%b_%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b_%b",
        name, act[8], act[7:6], act[5], act[4], act[3:1], act[0],
        exp[8], exp[7:6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  initial begin
    logic [2:0] s;
    logic [2:0] nx;
    logic [8:0] e;

    // manual bring-up, oinv, change during blank, en drop mid-blank
    add(1,0,0,2,1,0,1,  0,2,1,0,0,1);
    add(1,0,0,2,1,0,7,  0,2,1,0,0,1);
    add(1,0,0,2,1,0,1,  1,2,1,0,0,0);
    add(1,0,0,2,1,1,1,  1,2,1,1,0,0);
    add(1,0,0,2,1,0,1,  1,2,1,0,0,0);
    add(1,0,0,3,1,0,1,  0,3,1,0,0,1);
    add(1,0,0,0,0,0,8,  1,3,1,0,0,0);
    add(1,0,0,0,0,0,1,  0,0,0,0,0,1);
    add(0,0,0,0,0,0,1,  0,0,0,0,0,0);
    add(1,0,0,0,0,0,1,  0,0,0,0,0,1);
    add(1,0,0,0,0,0,7,  0,0,0,0,0,1);
    add(1,0,0,0,0,0,1,  1,0,0,0,0,0);
    // enter auto: held step applied, then dwell-driven walk 0..7,0
    add(1,1,0,0,0,0,1,  0,0,0,0,0,1);
    add(1,1,0,0,0,0,8,  1,0,0,0,0,0);
    add(1,1,0,0,0,0,11, 1,0,0,0,0,0);
    add(1,1,0,0,0,0,1,  0,1,0,0,1,1);
    for (int k = 1; k < 8; k++) begin
      s  = 3'(k);
      nx = 3'(k + 1);
      add(1,1,0,0,0,0,8,  1,s[1:0],s[2],0,s,0);
      add(1,1,0,0,0,0,11, 1,s[1:0],s[2],0,s,0);
      add(1,1,0,0,0,0,1,  0,nx[1:0],nx[2],0,nx,1);
    end
    // button in blank ignored; button with dwell expiry is one step
    add(1,1,1,0,0,0,1,  0,0,0,0,0,1);
    add(1,1,0,0,0,0,6,  0,0,0,0,0,1);
    add(1,1,0,0,0,0,1,  1,0,0,0,0,0);
    add(1,1,0,0,0,0,11, 1,0,0,0,0,0);
    add(1,1,1,0,0,0,1,  0,1,0,0,1,1);
    add(1,1,1,0,0,0,8,  1,1,0,0,1,0);
    add(1,1,0,0,0,0,1,  1,1,0,0,1,0);
    add(1,1,1,0,0,0,1,  0,2,0,0,2,1);
    // en drop holds step, re-enable gives full blank without advance
    add(0,1,1,0,0,0,1,  0,2,0,0,2,0);
    add(1,1,1,0,0,0,1,  0,2,0,0,2,1);
    add(1,1,1,0,0,0,7,  0,2,0,0,2,1);
    add(1,1,1,0,0,0,1,  1,2,0,0,2,0);

    repeat (3) @(negedge clk);
    check("reset", 9'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_off", 9'd0);

    foreach (vecs[i]) begin
      en_in     = vecs[i].en;
      auto_in   = vecs[i].au;
      btn_next  = vecs[i].btn;
      man_mode  = vecs[i].mm;
      man_speed = vecs[i].ms;
      man_oinv  = vecs[i].oi;
      sb.push_back(vecs[i].exp);
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d", i), e);
    end

    // async reset asserted between edges while running
    #2 rst_n = 1'b0;
    #1 check("async_reset", 9'd0);
    @(negedge clk);
    check("reset_held", 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kitt_mode_sequencer.md
Name: kitt_mode_sequencer

Overview:
Controller that sits between the debounced user inputs and the KITT scan core. It drives the core's ENA, MODE, SPEED and OINV inputs. It runs either in manual pass-through or in an auto-demo that steps through all 8 MODE/SPEED combinations on a dwell timer. Every pattern change is sequenced through a fixed blanking interval with ENA low, so the core always restarts cleanly from a known state.

Parameters:
PRESCALE, 10000, clk cycles per internal tick (1 ms at 10 MHz)
DWELL_TICKS, 2000, ticks per auto step
BLANK_TICKS, 50, ticks of ENA-low blanking on every config change

Ports:
clk  input  1  system clock (10 MHz)
rst_n  input  1  asynchronous active-low reset
en_in  input  1  debounced master enable, level
auto_in  input  1  1 = auto-demo, 0 = manual
btn_next  input  1  debounced step button, level; rising edge detected internally
man_mode  input  2  manual MODE request
man_speed  input  1  manual SPEED request
man_oinv  input  1  output-invert request, applies in both modes
core_ena  output  1  to core ENA
core_mode  output  2  to core MODE
core_speed  output  1  to core SPEED
core_oinv  output  1  to core OINV
step_idx  output  3  current auto step
busy  output  1  1 while in BLANK

Behaviour:
- Clock and reset: single clock domain. rst_n asynchronous, active-low. All outputs are registered.
- Reset values: state OFF; core_ena 0, core_mode 00, core_speed 0, core_oinv 0, step_idx 0, busy 0. Prescaler, dwell and blank counters all 0. btn_next edge register 0.
- Prescaler: counts 0..PRESCALE-1. tick is asserted when the count equals PRESCALE-1. The prescaler is cleared on entry to BLANK and on entry to RUN, so interval lengths are exact.
- States:
  - OFF: core_ena=0.
  - BLANK: core_ena=0, busy=1.
  - RUN: core_ena=1.
- Transitions (each sampled input takes effect on the next clock edge):
  - OFF -> BLANK when en_in=1.
  - BLANK -> RUN after exactly BLANK_TICKS*PRESCALE cycles in BLANK.
  - RUN -> BLANK on a change event.
  - Any state -> OFF when en_in=0. This has highest priority. Counters are cleared; step_idx and the config registers hold.
- Change events, evaluated in RUN only:
  - auto_in differs from its registered copy.
  - Manual (auto_in=0): {man_mode, man_speed} differs from {core_mode, core_speed}.
  - Auto (auto_in=1): dwell expiry (tick while dwell count = DWELL_TICKS-1), or a btn_next rising edge.
- Config load: on entry to BLANK, core_mode, core_speed and the registered auto_in copy are loaded in the same edge that drops core_ena.
  - Manual: core_mode=man_mode, core_speed=man_speed.
  - Auto: step_idx advances first (7 wraps to 0) if the event was dwell or button, then core_mode=step_idx[1:0], core_speed=step_idx[2].
  - Entering auto from manual: step_idx is not advanced; the current step is applied.
  - OFF->BLANK loads the config using the same rules, with no advance.
- core_oinv follows man_oinv with 1-cycle latency in every state, with no blanking (polarity only).
- Dwell counter: cleared on entry to RUN. Increments on tick in RUN, in auto mode only.
- Boundary cases:
  - btn_next edge and dwell expiry in the same cycle: a single advance.
  - btn_next edges in OFF, BLANK or manual mode: ignored, not queued.
  - Input changes during BLANK: not applied. They are re-evaluated in the first RUN cycle, which triggers a new BLANK if they still differ.
  - en_in dropping mid-BLANK: OFF next cycle. The next en_in rise gives a full-length BLANK.
  - PRESCALE=1: tick asserted every cycle.

Test Plan:
(All tests use PRESCALE=4, DWELL_TICKS=3, BLANK_TICKS=2, giving blank = 8 cycles and dwell = 12 cycles.)
1. Reset then en_in=1, auto_in=0, man_mode=2, man_speed=1 at cycle N -> busy=1 and core_mode=2, core_speed=1 at N+1; core_ena=1 at N+9.
2. Auto, RUN at step 0 -> every 12 RUN cycles step_idx advances 0,1,..,7,0, each advance followed by 8 cycles of core_ena=0. At step 5: core_mode=1, core_speed=1.
3. Auto, btn_next rises in the same cycle as dwell expiry -> step_idx +1 only. btn_next rise during BLANK -> no change.
4. Manual RUN, toggle man_oinv -> core_oinv follows 1 cycle later, core_ena stays 1. Change man_mode during BLANK -> new BLANK starts in the first RUN cycle.
5. en_in=0 mid-BLANK -> core_ena=0, busy=0 next cycle, step_idx held. en_in=1 again -> full 8-cycle BLANK.
6. Assert rst_n low mid-RUN, asynchronously between edges -> all outputs go to their reset values immediately.
